calc_result_history: RTL and testbench
======================================

# calc_result_history

Parametrised result register with recall history for the calculator datapath. Holds the current result like the existing enabled result register, and also records every loaded result in a circular buffer of DEPTH entries. Sits after the adder/ALU output; the display path reads `q` (latest result) or `recall_q` (a stepped-back earlier result).

## Interface
- `WIDTH`, 5, result word width (sum + carry).
- `DEPTH`, 8, history entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `enable`  in  1  load `data` into `q` and push it into history.
- `data`  in  WIDTH  result to load.
- `recall_prev`  in  1  step recall one entry older.
- `recall_next`  in  1  step recall one entry newer.
- `clear`  in  1  empty history (does not touch `q`).
- `q`  out  WIDTH  latest loaded result.
- `recall_q`  out  WIDTH  history entry at current recall offset; 0 when empty.
- `recall_valid`  out  1  history non-empty.
- `count`  out  $clog2(DEPTH+1)  valid entries, saturates at DEPTH.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky overwrite flag (only with `CALC_HIST_OVF_EN`).

## Operation
- State: `q`, memory[DEPTH], `wr_ptr` (log2 DEPTH), `count`, `offset` (0 = newest).
- Load (`enable`=1): `q <= data`; mem[wr_ptr] <= data; `wr_ptr` increments, wraps DEPTH-1 → 0; `count` +1 saturating at DEPTH; `offset <= 0`.
- Full + load: oldest entry overwritten; `count` stays DEPTH.
- `recall_prev` alone: `offset` +1 if `offset < count-1`, else hold.
- `recall_next` alone: `offset` -1 if `offset > 0`, else hold.
- Both recall inputs high: no change.
- Priority: `clear` > load > recall, applied to history state only; `q` loads on `enable` regardless of `clear`.
- `clear`: `count`, `wr_ptr`, `offset` to 0; memory contents untouched (masked by `count`).
- `recall_q` = mem[(wr_ptr - 1 - offset) mod DEPTH] when `count>0`, else 0.
- Memory not reset; never observable because reads are gated by `count`.

## Timing
- All state updates on rising `clk`; no combinational input-to-output paths.
- `q`, `count`, `full`, `recall_valid`: valid the cycle after the edge that loads.
- `recall_q`: decoded from registered pointers; reflects a load or recall step one cycle after the edge.
- Reset (`rst_n`=0 at an edge): `q`=0, `recall_q`=0, `recall_valid`=0, `count`=0, `full`=0, `overflow`=0, `wr_ptr`=0, `offset`=0. Reset overrides all inputs, including mid-recall or mid-load.
- Back-to-back loads every cycle are supported; each one is recorded.

## Configuration
- `CALC_HIST_OVF_EN` defined: `overflow` sets when a load occurs while `full`=1; stays set until `clear` or reset; set-and-clear in the same cycle leaves it 0.
- Not defined: the `overflow` port is present but tied to 0; no sticky flop is built.

## Structure
- `calc_pkg`: default `WIDTH`/`DEPTH` localparams and a pointer-width constant; shared with the ALU and display blocks.
- Sub-module `calc_hist_mem`: DEPTH×WIDTH array with one synchronous write port and one asynchronous read port. Pointer, offset and count logic stays in the top module.

## Test plan
- Reset with `enable`=1, `data`=5'h1F asserted -> all outputs 0 the cycle after the edge.
- Load 3, 7, 12 -> `q`=12, `count`=3, `recall_q`=12; `recall_prev` ×2 -> 7 then 3; a third `recall_prev` -> stays 3.
- DEPTH=8: load 1..10 -> `full`=1, `count`=8; `recall_prev` ×7 -> `recall_q`=3 (oldest); `overflow`=1 only with the macro defined.
- At `offset`=2, load 9 together with `recall_prev` -> `offset`=0, `recall_q`=9.
- `clear` and `enable` with `data`=4 in the same cycle -> `q`=4, `count`=0, `recall_valid`=0, `recall_q`=0.
- `recall_prev` and `recall_next` together at `offset`=1 -> `offset` unchanged; `recall_next` at `offset`=0 -> holds at newest.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator datapath constants: default result width, history depth
// and the matching history pointer width. Used by the ALU, display and
// result-history blocks.
package calc_pkg;

    localparam int CALC_WIDTH = 5;
    localparam int CALC_DEPTH = 8;
    localparam int CALC_PTR_W = $clog2(CALC_DEPTH);

endpackage : calc_pkg

// File: rtl/calc_hist_mem.sv
// History storage for calc_result_history: DEPTH x WIDTH array with one
// synchronous write port and one asynchronous read port. Contents are not
// reset; the owner masks reads with its valid-entry count.
module calc_hist_mem
    import calc_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DEPTH  = CALC_DEPTH,
    parameter int ADDR_W = CALC_PTR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on a load
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : calc_hist_mem

// File: rtl/calc_result_history.sv
// Result register with recall history. q holds the latest loaded result;
// every load is also pushed into a circular history of DEPTH entries that
// can be stepped through with recall_prev / recall_next.
// Optional feature macro: CALC_HIST_OVF_EN builds the sticky overflow flag
// (set on a load while full); without it, overflow is tied to 0.
module calc_result_history
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH,
    parameter int DEPTH = CALC_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           data,
    input  logic                       recall_prev,
    input  logic                       recall_next,
    input  logic                       clear,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           recall_q,
    output logic                       recall_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] q_reg;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] offset_reg, offset_next;
    logic [PTR_W-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             mem_we;

    // Latest result: loads on enable regardless of clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (enable) begin
            q_reg <= data;
        end
    end

    // History pointer/count/offset next state: clear > load > recall step
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        offset_next = offset_reg;
        if (clear) begin
            wr_ptr_next = '0;
            count_next  = '0;
            offset_next = '0;
        end else if (enable) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            if (count_reg != CNT_W'(DEPTH)) begin
                count_next = count_reg + CNT_W'(1);
            end
            offset_next = '0;
        end else if (recall_prev && !recall_next) begin
            // Step older only while an older valid entry exists
            if ((CNT_W'(offset_reg) + CNT_W'(1)) < count_reg) begin
                offset_next = offset_reg + PTR_W'(1);
            end
        end else if (recall_next && !recall_prev) begin
            if (offset_reg != '0) begin
                offset_next = offset_reg - PTR_W'(1);
            end
        end
    end

    // History state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            offset_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            offset_reg <= offset_next;
        end
    end

    // A clear wins over the push, so the entry is not recorded
    assign mem_we  = enable && !clear;
    // Newest entry sits just behind the write pointer; wraps modulo DEPTH
    assign rd_addr = wr_ptr_reg - PTR_W'(1) - offset_reg;

    calc_hist_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_reg),
        .wdata (data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign q            = q_reg;
    assign count        = count_reg;
    assign full         = (count_reg == CNT_W'(DEPTH));
    assign recall_valid = (count_reg != '0);
    // Unreset memory is never visible: gate reads by the valid count
    assign recall_q     = recall_valid ? rd_data : '0;

`ifdef CALC_HIST_OVF_EN
    logic ovf_reg;

    // Sticky overwrite flag; clear beats a same-cycle set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (clear) begin
            ovf_reg <= 1'b0;
        end else if (enable && full) begin
            ovf_reg <= 1'b1;
        end
    end

    assign overflow = ovf_reg;
`else
    assign overflow = 1'b0;
`endif

endmodule : calc_result_history

// File: tb/tb_calc_result_history.sv
// Self-checking bench for calc_result_history: directed scenarios plus a
// randomized run against a queue-based reference model of the history.
module tb_calc_result_history;

    localparam int W  = 5;
    localparam int D  = 8;
    localparam int CW = $clog2(D+1);
`ifdef CALC_HIST_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [W-1:0]  data;
    logic          recall_prev;
    logic          recall_next;
    logic          clear;
    logic [W-1:0]  q;
    logic [W-1:0]  recall_q;
    logic          recall_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;

    int vectors = 0;
    int errors  = 0;

    // Reference model: history queue, newest at the back
    int m_q;
    int hist[$];
    int m_off;
    bit m_ovf;

    calc_result_history #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .data         (data),
        .recall_prev  (recall_prev),
        .recall_next  (recall_next),
        .clear        (clear),
        .q            (q),
        .recall_q     (recall_q),
        .recall_valid (recall_valid),
        .count        (count),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic int m_recall();
        if (hist.size() == 0) return 0;
        return hist[hist.size() - 1 - m_off];
    endfunction

    // Apply one cycle of inputs, advance the model, settle 1 time unit past the edge
    task automatic step(input bit r, input bit en, input int d,
                        input bit p, input bit n, input bit c);
        rst_n = ~r; enable = en; data = d[W-1:0];
        recall_prev = p; recall_next = n; clear = c;
        @(posedge clk);
        if (r) begin
            m_q = 0; hist.delete(); m_off = 0; m_ovf = 0;
        end else begin
            if (en) m_q = d % (1 << W);
            if (c) begin
                hist.delete(); m_off = 0; m_ovf = 0;
            end else if (en) begin
                if (hist.size() == D) begin
                    void'(hist.pop_front());
                    if (OVF_EN) m_ovf = 1;
                end
                hist.push_back(d % (1 << W));
                m_off = 0;
            end else if (p && !n) begin
                if (m_off < hist.size() - 1) m_off++;
            end else if (n && !p) begin
                if (m_off > 0) m_off--;
            end
        end
        #1;
        rst_n = 1'b1; enable = 1'b0; recall_prev = 1'b0; recall_next = 1'b0; clear = 1'b0;
        $display("txn rst=%0b en=%0b d=%0d prev=%0b next=%0b clr=%0b -> q=%0d recall_q=%0d cnt=%0d full=%0b ovf=%0b",
                 r, en, d % (1 << W), p, n, c, q, recall_q, count, full, overflow);
    endtask

    task automatic test_reset();
        step(1, 1, 31, 1, 0, 0);
        vectors++; if (q !== '0) begin errors++; $display("FAIL reset_q got %0d want 0", q); end
        vectors++; if (recall_q !== '0) begin errors++; $display("FAIL reset_recall_q got %0d want 0", recall_q); end
        vectors++; if (recall_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", recall_valid); end
        vectors++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    endtask

    task automatic test_basic_recall();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0);
        step(0, 1, 12, 0, 0, 0);
        vectors++; if (q !== 5'd12) begin errors++; $display("FAIL basic_q got %0d want 12", q); end
        vectors++; if (count !== CW'(3)) begin errors++; $display("FAIL basic_count got %0d want 3", count); end
        vectors++; if (recall_q !== 5'd12) begin errors++; $display("FAIL basic_newest got %0d want 12", recall_q); end
        step(0, 0, 0, 1, 0, 0);
        vectors++; if (recall_q !== 5'd7) begin errors++; $display("FAIL basic_prev1 got %0d want 7", recall_q); end
        step(0, 0, 0, 1, 0, 0);
        vectors++; if (recall_q !== 5'd3) begin errors++; $display("FAIL basic_prev2 got %0d want 3", recall_q); end
        step(0, 0, 0, 1, 0, 0);
        vectors++; if (recall_q !== 5'd3) begin errors++; $display("FAIL basic_prev_hold got %0d want 3", recall_q); end
    endtask

    task automatic test_wrap_full();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) step(0, 1, i, 0, 0, 0);
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_full got %0b want 1", full); end
        vectors++; if (count !== CW'(8)) begin errors++; $display("FAIL wrap_count got %0d want 8", count); end
        vectors++; if (recall_q !== 5'd10) begin errors++; $display("FAIL wrap_newest got %0d want 10", recall_q); end
        vectors++; if (overflow !== OVF_EN) begin errors++; $display("FAIL wrap_ovf got %0b want %0b", overflow, OVF_EN); end
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0);
        vectors++; if (recall_q !== 5'd3) begin errors++; $display("FAIL wrap_oldest got %0d want 3", recall_q); end
        step(0, 0, 0, 1, 0, 0);
        vectors++; if (recall_q !== 5'd3) begin errors++; $display("FAIL wrap_oldest_hold got %0d want 3", recall_q); end
    endtask

    task automatic test_load_during_recall();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, i, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        vectors++; if (recall_q !== 5'd3) begin errors++; $display("FAIL ldrec_off2 got %0d want 3", recall_q); end
        step(0, 1, 9, 1, 0, 0);
        vectors++; if (recall_q !== 5'd9) begin errors++; $display("FAIL ldrec_newest got %0d want 9", recall_q); end
        vectors++; if (q !== 5'd9) begin errors++; $display("FAIL ldrec_q got %0d want 9", q); end
        step(0, 0, 0, 1, 0, 0);
        vectors++; if (recall_q !== 5'd5) begin errors++; $display("FAIL ldrec_prev got %0d want 5", recall_q); end
    endtask

    task automatic test_clear_with_load();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) step(0, 1, i + 20, 0, 0, 0);
        step(0, 1, 4, 0, 0, 1);
        vectors++; if (q !== 5'd4) begin errors++; $display("FAIL clr_q got %0d want 4", q); end
        vectors++; if (count !== '0) begin errors++; $display("FAIL clr_count got %0d want 0", count); end
        vectors++; if (recall_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %0b want 0", recall_valid); end
        vectors++; if (recall_q !== '0) begin errors++; $display("FAIL clr_recall_q got %0d want 0", recall_q); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b want 0", overflow); end
        step(0, 1, 6, 0, 0, 0);
        vectors++; if (recall_q !== 5'd6) begin errors++; $display("FAIL clr_reload got %0d want 6", recall_q); end
        vectors++; if (count !== CW'(1)) begin errors++; $display("FAIL clr_reload_count got %0d want 1", count); end
    endtask

    task automatic test_both_recall();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 10, 0, 0, 0);
        step(0, 1, 20, 0, 0, 0);
        step(0, 1, 30, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        vectors++; if (recall_q !== 5'd20) begin errors++; $display("FAIL both_off1 got %0d want 20", recall_q); end
        step(0, 0, 0, 1, 1, 0);
        vectors++; if (recall_q !== 5'd20) begin errors++; $display("FAIL both_hold got %0d want 20", recall_q); end
        step(0, 0, 0, 0, 1, 0);
        vectors++; if (recall_q !== 5'd30) begin errors++; $display("FAIL both_next got %0d want 30", recall_q); end
        step(0, 0, 0, 0, 1, 0);
        vectors++; if (recall_q !== 5'd30) begin errors++; $display("FAIL both_next_hold got %0d want 30", recall_q); end
    endtask

    task automatic test_random();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
            vectors++; if (q !== W'(m_q)) begin errors++; $display("FAIL rnd_q got %0d want %0d", q, m_q); end
            vectors++; if (recall_q !== W'(m_recall())) begin errors++; $display("FAIL rnd_recall_q got %0d want %0d", recall_q, m_recall()); end
            vectors++; if (count !== CW'(hist.size())) begin errors++; $display("FAIL rnd_count got %0d want %0d", count, hist.size()); end
            vectors++; if (recall_valid !== (hist.size() != 0)) begin errors++; $display("FAIL rnd_valid got %0b want %0b", recall_valid, hist.size() != 0); end
            vectors++; if (full !== (hist.size() == D)) begin errors++; $display("FAIL rnd_full got %0b want %0b", full, hist.size() == D); end
            vectors++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf got %0b want %0b", overflow, m_ovf); end
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; data = '0;
        recall_prev = 1'b0; recall_next = 1'b0; clear = 1'b0;
        m_q = 0; m_off = 0; m_ovf = 0;
        test_reset();
        test_basic_recall();
        test_wrap_full();
        test_load_during_recall();
        test_clear_with_load();
        test_both_recall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_calc_result_history
